// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (instruction fetch / load-store) arbiter and
// sequencer in front of a single-port program memory with a one-cycle
// synchronous read.
// Each access is IDLE -> ISSUE -> RESP, or IDLE -> RESP when the address
// falls outside the window or is not word aligned.
// Optional feature macro: ROM_ARB_ROUND_ROBIN_EN. When it is defined, ties
// alternate between the ports. When it is undefined, the data port always
// wins a tie.
module rom_arbiter #(
   parameter logic [31:0] BASE_ADDR    = 32'h0800_0000,
   parameter logic [31:0] WINDOW_BYTES = 32'd256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifetch_req,
   input  logic [31:0] ifetch_addr,
   output logic        ifetch_ack,
   output logic [31:0] ifetch_rdata,
   output logic        ifetch_err,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_ack,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic        mem_write_enable,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        win_data_q, win_data_d;   // 1 = data port holds the grant
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        mem_write_enable_q, mem_write_enable_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_data_in_q, mem_data_in_d;
   logic        ifetch_ack_q, ifetch_ack_d;
   logic        ifetch_err_q, ifetch_err_d;
   logic        data_ack_q, data_ack_d;
   logic        data_err_q, data_err_d;

   logic        any_req;
   logic        pick_data;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] offset;
   logic        addr_ok;

   assign any_req = data_req | ifetch_req;

`ifdef ROM_ARB_ROUND_ROBIN_EN
   logic last_data_q, last_data_d;   // 1 = the last grant went to the data port

   // On a tie, grant the port that was not granted last.
   always_comb begin
      pick_data = data_req & (~ifetch_req | ~last_data_q);
   end

   // The pointer moves only when a grant is actually made.
   always_comb begin
      last_data_d = last_data_q;
      if ((state_q == ST_IDLE) && any_req) begin
         last_data_d = pick_data;
      end
   end

   // Reset leaves the pointer at "last = fetch", so data wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_data_q <= 1'b0;
      end else begin
         last_data_q <= last_data_d;
      end
   end
`else
   assign pick_data = data_req;
`endif

   // Window check. An address below BASE_ADDR wraps to a huge offset, so a
   // single unsigned compare also rejects it.
   always_comb begin
      sel_addr = pick_data ? data_addr : ifetch_addr;
      sel_we   = pick_data & data_we;
      offset   = sel_addr - BASE_ADDR;
      addr_ok  = (offset < WINDOW_BYTES) && (sel_addr[1:0] == 2'b00);
   end

   // Sequencer: latches the winning request in IDLE. It drives the memory
   // only for the ISSUE cycle and raises the ack/err registers as RESP starts.
   always_comb begin
      state_d            = state_q;
      win_data_d         = win_data_q;
      we_d               = we_q;
      err_d              = err_q;
      mem_write_enable_d = 1'b0;
      mem_address_d      = '0;
      mem_data_in_d      = '0;
      ifetch_ack_d       = 1'b0;
      ifetch_err_d       = 1'b0;
      data_ack_d         = 1'b0;
      data_err_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               win_data_d = pick_data;
               we_d       = sel_we;
               err_d      = ~addr_ok;
               if (addr_ok) begin
                  state_d            = ST_ISSUE;
                  mem_address_d      = offset;
                  mem_data_in_d      = sel_we ? data_wdata : '0;
                  mem_write_enable_d = sel_we;
               end else begin
                  state_d      = ST_RESP;
                  data_ack_d   = pick_data;
                  data_err_d   = pick_data;
                  ifetch_ack_d = ~pick_data;
                  ifetch_err_d = ~pick_data;
               end
            end
         end
         ST_ISSUE: begin
            state_d      = ST_RESP;
            data_ack_d   = win_data_q;
            ifetch_ack_d = ~win_data_q;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs. The asynchronous reset drops
   // mem_write_enable immediately, which aborts a store that is in ISSUE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         win_data_q         <= 1'b0;
         we_q               <= 1'b0;
         err_q              <= 1'b0;
         mem_write_enable_q <= 1'b0;
         mem_address_q      <= '0;
         mem_data_in_q      <= '0;
         ifetch_ack_q       <= 1'b0;
         ifetch_err_q       <= 1'b0;
         data_ack_q         <= 1'b0;
         data_err_q         <= 1'b0;
      end else begin
         state_q            <= state_d;
         win_data_q         <= win_data_d;
         we_q               <= we_d;
         err_q              <= err_d;
         mem_write_enable_q <= mem_write_enable_d;
         mem_address_q      <= mem_address_d;
         mem_data_in_q      <= mem_data_in_d;
         ifetch_ack_q       <= ifetch_ack_d;
         ifetch_err_q       <= ifetch_err_d;
         data_ack_q         <= data_ack_d;
         data_err_q         <= data_err_d;
      end
   end

   assign mem_write_enable = mem_write_enable_q;
   assign mem_address      = mem_address_q;
   assign mem_data_in      = mem_data_in_q;
   assign ifetch_ack       = ifetch_ack_q;
   assign ifetch_err       = ifetch_err_q;
   assign data_ack         = data_ack_q;
   assign data_err         = data_err_q;

   // Read data appears only during RESP, only for the winner, and only for
   // a valid load or fetch. It passes straight through from the memory,
   // because memory data is not valid until the edge that enters RESP.
   assign data_rdata   = ((state_q == ST_RESP) && win_data_q && !err_q && !we_q)
                         ? mem_data_out : '0;
   assign ifetch_rdata = ((state_q == ST_RESP) && !win_data_q && !err_q)
                         ? mem_data_out : '0;

endmodule
